// File: rtl/aes_iter_engine.sv
// Iterative AES-128/192/256 encryption engine: the key is expanded once into a
// round-key file (one word per clock), then each block takes one round per clock.
module aes_iter_engine #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] anahtar,
    input  logic                anahtar_gecerli,
    output logic                anahtar_hazir,
    input  logic [127:0]        blok,
    input  logic                g_gecerli,
    output logic                hazir,
    output logic [127:0]        sifre,
    output logic                c_gecerli,
    input  logic                c_hazir
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
            $fatal(1, "aes_iter_engine: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    // S-box byte 0x00 sits in the top byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] idx;
        idx  = 8'd255 - b;
        sbox = SBOX_TBL[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        subword = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        mix_col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte (row r, column c) lives at state byte 4c+r; ShiftRows pulls column (c+r)%4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        sub_shift = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        mix_cols = 128'h0;
        for (int c = 0; c < 4; c++) begin
            mix_cols[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
        end
    endfunction

    typedef enum logic [2:0] {
        NOKEY  = 3'd0,
        KEYEXP = 3'd1,
        IDLE   = 3'd2,
        ROUND  = 3'd3,
        OUT    = 3'd4
    } fsm_e;

    fsm_e         fsm_q;
    logic [31:0]  w_q [NW];
    logic [5:0]   widx_q;
    logic [2:0]   kmod_q;
    logic [7:0]   rcon_q;
    logic [3:0]   rnd_q;
    logic [127:0] st_q;
    logic [127:0] sifre_q;
    logic         c_gecerli_q;

    logic         key_hs_s;
    logic         blk_hs_s;
    logic [31:0]  prev_s;
    logic [31:0]  sw_in_s;
    logic [31:0]  sw_s;
    logic [31:0]  f_s;
    logic [31:0]  kw_d;
    logic [127:0] rk_s;
    logic [127:0] rk0_s;
    logic [127:0] ss_s;
    logic [127:0] round_d;

    assign anahtar_hazir = (fsm_q == NOKEY) || (fsm_q == IDLE);
    assign hazir         = (fsm_q == IDLE) && !anahtar_gecerli;
    assign key_hs_s      = anahtar_gecerli && anahtar_hazir;
    assign blk_hs_s      = g_gecerli && hazir;
    assign sifre         = sifre_q;
    assign c_gecerli     = c_gecerli_q;

    // Next key-schedule word; kmod_q tracks the word index modulo NK.
    always_comb begin
        prev_s = w_q[widx_q - 6'd1];
        if (kmod_q == 3'd0) begin
            sw_in_s = {prev_s[23:0], prev_s[31:24]};
        end else begin
            sw_in_s = prev_s;
        end
        sw_s = subword(sw_in_s);
        if (kmod_q == 3'd0) begin
            f_s = sw_s ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            f_s = sw_s;
        end else begin
            f_s = prev_s;
        end
        kw_d = w_q[widx_q - 6'(NK)] ^ f_s;
    end

    // One full cipher round on the state register; the last round skips MixColumns.
    always_comb begin
        rk_s  = {w_q[{rnd_q, 2'b00}], w_q[{rnd_q, 2'b01}], w_q[{rnd_q, 2'b10}], w_q[{rnd_q, 2'b11}]};
        rk0_s = {w_q[0], w_q[1], w_q[2], w_q[3]};
        ss_s  = sub_shift(st_q);
        if (rnd_q == 4'(NR)) begin
            round_d = ss_s ^ rk_s;
        end else begin
            round_d = mix_cols(ss_s) ^ rk_s;
        end
    end

    // Round-key file: contents are only meaningful once the FSM leaves NOKEY/KEYEXP.
    always_ff @(posedge clk) begin
        if (key_hs_s) begin
            for (int i = 0; i < NK; i++) begin
                w_q[i] <= anahtar[KEY_BITS - 1 - 32*i -: 32];
            end
        end else if (fsm_q == KEYEXP) begin
            w_q[widx_q] <= kw_d;
        end
    end

    // Control FSM with the round datapath and registered ciphertext outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= NOKEY;
            widx_q      <= 6'd0;
            kmod_q      <= 3'd0;
            rcon_q      <= 8'h00;
            rnd_q       <= 4'd0;
            st_q        <= 128'h0;
            sifre_q     <= 128'h0;
            c_gecerli_q <= 1'b0;
        end else begin
            case (fsm_q)
                NOKEY: begin
                    if (key_hs_s) begin
                        fsm_q  <= KEYEXP;
                        widx_q <= 6'(NK);
                        kmod_q <= 3'd0;
                        rcon_q <= 8'h01;
                    end
                end
                KEYEXP: begin
                    widx_q <= widx_q + 6'd1;
                    kmod_q <= (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
                    if (kmod_q == 3'd0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (widx_q == 6'(NW - 1)) begin
                        fsm_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (key_hs_s) begin
                        fsm_q  <= KEYEXP;
                        widx_q <= 6'(NK);
                        kmod_q <= 3'd0;
                        rcon_q <= 8'h01;
                    end else if (blk_hs_s) begin
                        fsm_q <= ROUND;
                        st_q  <= blok ^ rk0_s;
                        rnd_q <= 4'd1;
                    end
                end
                ROUND: begin
                    st_q  <= round_d;
                    rnd_q <= rnd_q + 4'd1;
                    if (rnd_q == 4'(NR)) begin
                        sifre_q     <= round_d;
                        c_gecerli_q <= 1'b1;
                        fsm_q       <= OUT;
                    end
                end
                OUT: begin
                    if (c_hazir) begin
                        c_gecerli_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q       <= NOKEY;
                    c_gecerli_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_engine.sv
// Bench for aes_iter_engine: AES-128/192/256 instances checked against FIPS-197
// vectors and a GF(2^8)-arithmetic reference model.
module tb_aes_iter_engine;
    logic             clk = 1'b0;
    logic             rst;
    logic [255:0]     key_bus;
    logic [127:0]     blok;
    logic [2:0]       kv, akh, gv, hz, cg, ch;
    logic [2:0][127:0] so;
    int               total, bad, cyc;
    logic [7:0]       sb [256];
    logic [127:0]     out_q [$];
    logic [255:0]     cur_key [3];

    typedef struct {
        int           nk;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t kat [3];

    aes_iter_engine #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst(rst), .anahtar(key_bus[255:128]), .anahtar_gecerli(kv[0]),
        .anahtar_hazir(akh[0]), .blok(blok), .g_gecerli(gv[0]), .hazir(hz[0]),
        .sifre(so[0]), .c_gecerli(cg[0]), .c_hazir(ch[0]));
    aes_iter_engine #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst(rst), .anahtar(key_bus[255:64]), .anahtar_gecerli(kv[1]),
        .anahtar_hazir(akh[1]), .blok(blok), .g_gecerli(gv[1]), .hazir(hz[1]),
        .sifre(so[1]), .c_gecerli(cg[1]), .c_hazir(ch[1]));
    aes_iter_engine #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst(rst), .anahtar(key_bus), .anahtar_gecerli(kv[2]),
        .anahtar_hazir(akh[2]), .blok(blok), .g_gecerli(gv[2]), .hazir(hz[2]),
        .sifre(so[2]), .c_gecerli(cg[2]), .c_hazir(ch[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (cg[0] && ch[0]) out_q.push_back(so[0]);

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [127:0] ref_enc(input int nk, input logic [255:0] key, input logic [127:0] pt);
        int           nr;
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gm(rc, 8'h02);
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ w[n/4][31 - 8*(n%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c + q] = t[4*((c + q) % 4) + q];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int q = 0; q < 4; q++) t[q] = s[4*c + q];
                    for (int q = 0; q < 4; q++)
                        s[4*c + q] = gm(t[q], 8'h02) ^ gm(t[(q+1)%4], 8'h03) ^ t[(q+2)%4] ^ t[(q+3)%4];
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31 - 8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic wait_exp(input int u, input int nk);
        int n = 0;
        while (!akh[u] && n < 200) begin tick(); n++; end
        chk("key_exp_cycles", n, 4*(nk + 7) - nk);
        chk("hazir_after_exp", hz[u], 1'b1);
    endtask

    task automatic load_key(input int u, input int nk, input logic [255:0] k);
        int n = 0;
        while (!akh[u] && n < 100) begin tick(); n++; end
        key_bus = k;
        kv[u] = 1'b1;
        tick();
        kv[u] = 1'b0;
        chk("key_taken", akh[u], 1'b0);
        cur_key[u] = k;
        wait_exp(u, nk);
    endtask

    task automatic encrypt(input int u, input int nr, input logic [127:0] pt, input logic [127:0] ct);
        int n = 0;
        blok = pt;
        gv[u] = 1'b1;
        while (!hz[u] && n < 100) begin tick(); n++; end
        chk("hazir_wait", hz[u], 1'b1);
        tick();
        gv[u] = 1'b0;
        blok = rnd128();
        n = 0;
        while (!cg[u] && n < 100) begin tick(); n++; end
        chk("latency", n, nr);
        chk("sifre", so[u], ct);
    endtask

    logic [127:0] pt, exp_ct;
    logic [127:0] pts [4];
    int           acc [4];
    int           n, nk;
    logic [255:0] k2;
    logic         seen;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; kv = 3'b000; gv = 3'b000; ch = 3'b111;
        key_bus = 256'h0; blok = 128'h0;
        for (int x = 1; x < 256; x++) sb[x] = 8'h00;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xv, yv, inv;
            xv = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yv = y[7:0];
                if (xv != 8'h00 && gm(xv, yv) == 8'h01) inv = yv;
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        kat[0].nk = 4;
        kat[0].key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        kat[0].pt = 128'h00112233445566778899aabbccddeeff;
        kat[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat[1].nk = 6;
        kat[1].key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        kat[1].pt = 128'h00112233445566778899aabbccddeeff;
        kat[1].ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat[2].nk = 8;
        kat[2].key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        kat[2].pt = 128'h00112233445566778899aabbccddeeff;
        kat[2].ct = 128'h8ea2b7ca516745bfeafc49904b496089;

        repeat (2) tick();
        chk("rst_anahtar_hazir", akh, 3'b111);
        chk("rst_hazir", hz, 3'b000);
        chk("rst_c_gecerli", cg, 3'b000);
        chk("rst_sifre0", so[0], 128'h0);
        chk("rst_sifre2", so[2], 128'h0);
        rst = 1'b0;
        tick();

        // Known-answer vectors for all three key sizes
        for (int i = 0; i < 3; i++) begin
            load_key((kat[i].nk - 4) / 2, kat[i].nk, kat[i].key);
            encrypt((kat[i].nk - 4) / 2, kat[i].nk + 6, kat[i].pt, kat[i].ct);
        end

        // Random keys and blocks against the reference model
        for (int u = 0; u < 3; u++) begin
            nk = 4 + 2*u;
            for (int kk = 0; kk < 2; kk++) begin
                load_key(u, nk, {rnd128(), rnd128()});
                for (int b = 0; b < 2; b++) begin
                    pt = rnd128();
                    encrypt(u, nk + 6, pt, ref_enc(nk, cur_key[u], pt));
                end
            end
        end

        // Output backpressure
        ch[0] = 1'b0;
        pt = rnd128();
        exp_ct = ref_enc(4, cur_key[0], pt);
        encrypt(0, 10, pt, exp_ct);
        for (int i = 0; i < 5; i++) begin
            gv[0] = 1'b1;
            blok = rnd128();
            tick();
            chk("bp_c_gecerli", cg[0], 1'b1);
            chk("bp_sifre", so[0], exp_ct);
            chk("bp_hazir", hz[0], 1'b0);
        end
        gv[0] = 1'b0;
        ch[0] = 1'b1;
        tick();
        chk("bp_release_cg", cg[0], 1'b0);
        chk("bp_release_hazir", hz[0], 1'b1);
        chk("bp_sifre_kept", so[0], exp_ct);
        repeat (3) tick();
        chk("bp_no_queued", cg[0], 1'b0);

        // Simultaneous key and block in IDLE: key wins
        k2 = {rnd128(), rnd128()};
        pt = rnd128();
        key_bus = k2; blok = pt;
        kv[0] = 1'b1; gv[0] = 1'b1;
        #1;
        chk("coll_hazir", hz[0], 1'b0);
        chk("coll_anahtar_hazir", akh[0], 1'b1);
        tick();
        kv[0] = 1'b0; gv[0] = 1'b0;
        chk("coll_key_taken", akh[0], 1'b0);
        cur_key[0] = k2;
        wait_exp(0, 4);
        chk("coll_no_output", cg[0], 1'b0);
        encrypt(0, 10, pt, ref_enc(4, k2, pt));

        // Back-to-back blocks with c_hazir tied high
        repeat (2) tick();
        out_q.delete();
        for (int b = 0; b < 4; b++) begin
            pts[b] = rnd128();
            blok = pts[b];
            gv[0] = 1'b1;
            n = 0;
            while (!hz[0] && n < 100) begin tick(); n++; end
            acc[b] = cyc;
            tick();
        end
        gv[0] = 1'b0;
        n = 0;
        while (out_q.size() < 4 && n < 200) begin tick(); n++; end
        chk("b2b_count", out_q.size(), 4);
        for (int b = 1; b < 4; b++) chk("b2b_spacing", acc[b] - acc[b-1], 12);
        for (int b = 0; b < 4; b++)
            chk("b2b_ct", (out_q.size() > b) ? out_q[b] : 128'h0, ref_enc(4, k2, pts[b]));

        // Reset in the middle of a block
        pt = rnd128();
        blok = pt;
        gv[0] = 1'b1;
        n = 0;
        while (!hz[0] && n < 100) begin tick(); n++; end
        tick();
        gv[0] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_c_gecerli", cg[0], 1'b0);
        chk("midrst_hazir", hz[0], 1'b0);
        chk("midrst_anahtar_hazir", akh[0], 1'b1);
        chk("midrst_sifre", so[0], 128'h0);
        seen = 1'b0;
        gv[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cg[0] || hz[0]) seen = 1'b1;
        end
        gv[0] = 1'b0;
        chk("midrst_ignored", seen, 1'b0);
        load_key(0, 4, {rnd128(), rnd128()});
        pt = rnd128();
        encrypt(0, 10, pt, ref_enc(4, cur_key[0], pt));
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
